iter_divider: RTL and testbench
===============================

// Module: iter_divider
// PURPOSE
//   Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
//   Sits beside the single-cycle ALU in the execute stage. Takes one request per
//   valid/ready handshake and returns one result per valid/ready handshake.
//   Execute stalls while busy is high.
// PARAMETERS
//   XLEN   32  operand/result width
//   TAG_W  5   width of opaque tag (rd index) carried from request to result
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   flush      in   1      abort in-flight op (pipeline kill)
//   in_valid   in   1      request valid
//   in_ready   out  1      high only in IDLE
//   div_op     in   2      div_op_t: DIV=0, DIVU=1, REM=2, REMU=3
//   dividend   in   XLEN   rs1
//   divisor    in   XLEN   rs2
//   in_tag     in   TAG_W  tag captured with request
//   out_valid  out  1      result valid; held until out_ready
//   out_ready  in   1      consumer accepts result
//   result     out  XLEN   quotient or remainder per div_op
//   out_tag    out  TAG_W  tag of the op that produced result
//   busy       out  1      state != IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, out_valid=0, busy=0, result=0, out_tag=0, count=0.
//     in_ready=1 after reset. Reset mid-op discards the op.
//   - Accept occurs when in_valid & in_ready. Operands, op and tag are latched on
//     the accept edge E0.
//   - FSM states: IDLE -> PREP -> ITER -> FIXUP -> DONE -> IDLE.
//     PREP: for signed ops, take the magnitude of each operand and record
//       q_neg = sign(a)^sign(b) and r_neg = sign(a). Detect special cases.
//     ITER: 32 cycles. count goes 0..31. Each cycle does one step:
//       {rem,quo} <<= 1; trial = rem - |divisor|; if trial >= 0 then rem = trial
//       and quo[0] = 1. Width is XLEN+1 so the borrow is visible.
//     FIXUP: negate quo if q_neg; negate rem if r_neg. Select the result by op.
//     DONE: out_valid=1. result and out_tag stay stable until out_ready.
//       The handshake edge moves to IDLE.
//   - Latency (edges from E0 until out_valid is high): 34 for a normal op;
//     1 for a special case (PREP goes straight to DONE).
//   - Special cases, fixed by the RISC-V spec, never trap:
//     divide by zero -> DIV/DIVU = all ones, REM/REMU = dividend.
//     signed overflow (0x80000000 / -1) -> DIV = 0x80000000, REM = 0.
//   - in_ready=0 in every state except IDLE. No overlap: a new op is accepted
//     only in the cycle after the result handshake.
//   - flush=1 in any state: next edge goes to IDLE and out_valid drops. The
//     result is discarded. flush has priority over an out handshake in the same
//     cycle. flush in IDLE together with in_valid: the request is not accepted.
//   - Priority order: reset > flush > normal FSM.
//   - Dividend 0 goes through the normal ITER path and gives q=0, r=0.
//   - All arithmetic is two's complement mod 2^XLEN. |0x80000000| is handled as
//     unsigned 0x80000000.
// STRUCTURE
//   - riscv_types package: add typedef enum logic [1:0] div_op_t {DIV, DIVU,
//     REM, REMU} and typedef enum div_state_t {IDLE, PREP, ITER, FIXUP, DONE}.
//   - One sub-module, div_restore_step: combinational, one shift-subtract
//     iteration. Inputs rem, quo, divisor; outputs next rem and next quo.
//   - FSM, counter and operand registers live in iter_divider.
// TESTING
//   1 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; out_valid exactly 34
//     edges after accept; out_tag equals in_tag.
//   2 DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF; REMU -> 0x0000000F; DIV 100/-7 -> -14;
//     REM 100/-7 -> 2.
//   3 DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIVU 0/0 -> 0xFFFFFFFF;
//     latency 1 edge.
//   4 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; no ITER cycles.
//   5 Hold out_ready=0 for 10 cycles in DONE: result and out_tag stable,
//     in_ready=0, in_valid pulses ignored. Release: IDLE on the next edge and
//     the next request is accepted after that.
//   6 Assert flush at ITER count=10: IDLE next edge, out_valid never rises,
//     busy=0. Repeat using reset instead of flush. A following DIVU 9/3 -> 3.

Source files
------------

// File: rtl/riscv_types_pkg.sv
// Shared RV32 execute-stage types: divider opcodes, divider FSM states and
// small opcode-decode helpers used by the multi-cycle divider.
package riscv_types;

    localparam int DIV_XLEN  = 32;
    localparam int DIV_TAG_W = 5;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        ITER  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } div_state_t;

    function automatic logic is_signed_op(input div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_rem_op(input div_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step: shift {rem,quo} left by one, try to
// subtract the divisor magnitude and keep the difference when no borrow occurs.
module div_restore_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] trial;
    logic            borrow;

    // One extra bit above the shifted partial remainder keeps the borrow as a sign bit.
    assign shifted  = {rem, quo[XLEN-1]};
    assign trial    = shifted - {2'b00, divisor};
    assign borrow   = trial[XLEN+1];

    assign rem_next = borrow ? shifted[XLEN:0] : trial[XLEN:0];
    assign quo_next = {quo[XLEN-2:0], ~borrow};

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU with valid/ready
// request and result handshakes, RISC-V special-case results and pipeline flush.
module iter_divider
    import riscv_types::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int TAG_W = DIV_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  div_op_t          div_op,
    input  logic [XLEN-1:0]  dividend,
    input  logic [XLEN-1:0]  divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
        return ~v + 1'b1;
    endfunction

    div_state_t       state_reg,  state_next;
    logic [CNT_W-1:0] count_reg,  count_next;
    div_op_t          op_reg,     op_next;
    logic [TAG_W-1:0] tag_reg,    tag_next;
    logic [XLEN-1:0]  a_reg,      a_next;
    logic [XLEN-1:0]  b_reg,      b_next;
    logic [XLEN-1:0]  dvsr_reg,   dvsr_next;
    logic [XLEN:0]    rem_reg,    rem_next;
    logic [XLEN-1:0]  quo_reg,    quo_next;
    logic             q_neg_reg,  q_neg_next;
    logic             r_neg_reg,  r_neg_next;
    logic [XLEN-1:0]  result_reg, result_next;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             div_by_zero;
    logic             overflow;
    logic [XLEN-1:0]  quo_fix;
    logic [XLEN-1:0]  rem_fix;
    logic [XLEN:0]    step_rem;
    logic [XLEN-1:0]  step_quo;

    assign signed_op   = is_signed_op(op_reg);
    assign a_neg       = signed_op & a_reg[XLEN-1];
    assign b_neg       = signed_op & b_reg[XLEN-1];
    // The most negative value maps onto itself, which is the correct unsigned magnitude.
    assign a_mag       = a_neg ? twos_neg(a_reg) : a_reg;
    assign b_mag       = b_neg ? twos_neg(b_reg) : b_reg;
    assign div_by_zero = (b_reg == '0);
    assign overflow    = signed_op && (a_reg == INT_MIN) && (b_reg == '1);

    assign quo_fix = q_neg_reg ? twos_neg(quo_reg) : quo_reg;
    assign rem_fix = r_neg_reg ? twos_neg(rem_reg[XLEN-1:0]) : rem_reg[XLEN-1:0];

    div_restore_step #(
        .XLEN     (XLEN)
    ) u_step (
        .rem      (rem_reg),
        .quo      (quo_reg),
        .divisor  (dvsr_reg),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            op_reg     <= DIV;
            tag_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            dvsr_reg   <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            q_neg_reg  <= 1'b0;
            r_neg_reg  <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            op_reg     <= op_next;
            tag_reg    <= tag_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            dvsr_reg   <= dvsr_next;
            rem_reg    <= rem_next;
            quo_reg    <= quo_next;
            q_neg_reg  <= q_neg_next;
            r_neg_reg  <= r_neg_next;
            result_reg <= result_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        op_next     = op_reg;
        tag_next    = tag_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        dvsr_next   = dvsr_reg;
        rem_next    = rem_reg;
        quo_next    = quo_reg;
        q_neg_next  = q_neg_reg;
        r_neg_next  = r_neg_reg;
        result_next = result_reg;

        // A kill from the pipeline beats both a pending request and a result handshake.
        if (flush) begin
            state_next = IDLE;
            count_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        op_next    = div_op;
                        tag_next   = in_tag;
                        a_next     = dividend;
                        b_next     = divisor;
                        state_next = PREP;
                    end
                end
                PREP: begin
                    q_neg_next = a_neg ^ b_neg;
                    r_neg_next = a_neg;
                    dvsr_next  = b_mag;
                    quo_next   = a_mag;
                    rem_next   = '0;
                    count_next = '0;
                    if (div_by_zero) begin
                        result_next = is_rem_op(op_reg) ? a_reg : '1;
                        state_next  = DONE;
                    end else if (overflow) begin
                        result_next = is_rem_op(op_reg) ? '0 : INT_MIN;
                        state_next  = DONE;
                    end else begin
                        state_next  = ITER;
                    end
                end
                ITER: begin
                    rem_next   = step_rem;
                    quo_next   = step_quo;
                    count_next = count_reg + 1'b1;
                    if (count_reg == LAST_STEP) begin
                        state_next = FIXUP;
                    end
                end
                FIXUP: begin
                    result_next = is_rem_op(op_reg) ? rem_fix : quo_fix;
                    state_next  = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign out_tag   = tag_reg;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: results, latencies, special cases,
// back-pressure in DONE, and flush/reset aborts, checked with immediate assertions.
module tb_iter_divider;
    import riscv_types::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    div_op_t     div_op = DIV;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [4:0]  out_tag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    iter_divider #(.XLEN(32), .TAG_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .div_op    (div_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Presents one request and returns #1 after the accept edge.
    task automatic start_op(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tag);
        div_op   = op;
        dividend = a;
        divisor  = b;
        in_tag   = tag;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Counts edges since the accept edge until out_valid, bounded.
    task automatic wait_result(input string name, input logic [31:0] exp_res,
                               input logic [4:0] exp_tag, input int exp_lat);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        $display("txn %s result=%h tag=%0d latency=%0d", name, result, out_tag, n);
        check({name, "_lat"}, n, exp_lat);
        check({name, "_res"}, result, exp_res);
        check({name, "_tag"}, {27'd0, out_tag}, {27'd0, exp_tag});
    endtask

    task automatic take_result(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_drop"}, {31'd0, out_valid}, 32'd0);
        check({name, "_rdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string name, input div_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp_res, input int exp_lat);
        start_op(op, a, b, tag);
        wait_result(name, exp_res, tag, exp_lat);
        take_result(name);
    endtask

    initial begin
        logic saw_valid;
        logic [31:0] held_res;
        logic [4:0]  held_tag;

        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_out_tag", {27'd0, out_tag}, 32'd0);

        // Signed division with truncation toward zero
        run_op("div_m7_2",   DIV,  32'hFFFFFFF9, 32'd2, 5'd19, 32'hFFFFFFFD, 34);
        run_op("rem_m7_2",   REM,  32'hFFFFFFF9, 32'd2, 5'd20, 32'hFFFFFFFF, 34);
        run_op("divu_big",   DIVU, 32'hFFFFFFFF, 32'h10, 5'd3, 32'h0FFFFFFF, 34);
        run_op("remu_big",   REMU, 32'hFFFFFFFF, 32'h10, 5'd4, 32'h0000000F, 34);
        run_op("div_100_m7", DIV,  32'd100, 32'hFFFFFFF9, 5'd5, 32'hFFFFFFF2, 34);
        run_op("rem_100_m7", REM,  32'd100, 32'hFFFFFFF9, 5'd6, 32'd2, 34);
        run_op("div_0_7",    DIV,  32'd0, 32'd7, 5'd7, 32'd0, 34);
        run_op("rem_0_7",    REM,  32'd0, 32'd7, 5'd8, 32'd0, 34);

        // Special cases resolve in PREP
        run_op("div_5_0",    DIV,  32'd5, 32'd0, 5'd9,  32'hFFFFFFFF, 1);
        run_op("remu_5_0",   REMU, 32'd5, 32'd0, 5'd10, 32'd5, 1);
        run_op("divu_0_0",   DIVU, 32'd0, 32'd0, 5'd11, 32'hFFFFFFFF, 1);
        run_op("div_ovf",    DIV,  32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1);
        run_op("rem_ovf",    REM,  32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0, 1);
        run_op("divu_min",   DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0, 34);

        // Back-pressure in DONE
        start_op(DIVU, 32'd50, 32'd7, 5'd21);
        wait_result("hold", 32'd7, 5'd21, 34);
        held_res = result;
        held_tag = out_tag;
        for (int i = 0; i < 10; i++) begin
            div_op   = DIV;
            dividend = 32'd1000 + i;
            divisor  = 32'd3;
            in_tag   = 5'(i);
            in_valid = i[0];
            tick();
            check("hold_res", result, held_res);
            check("hold_tag", {27'd0, out_tag}, {27'd0, held_tag});
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid  = 1'b1;
        div_op    = DIVU;
        dividend  = 32'd81;
        divisor   = 32'd9;
        in_tag    = 5'd30;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("rel_idle", {31'd0, in_ready}, 32'd1);
        check("rel_drop", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        check("rel_accept", {31'd0, busy}, 32'd1);
        wait_result("after_hold", 32'd9, 5'd30, 34);
        take_result("after_hold");

        // Flush in IDLE blocks the request
        flush    = 1'b1;
        div_op   = DIVU;
        dividend = 32'd4;
        divisor  = 32'd2;
        in_valid = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_idle_busy", {31'd0, busy}, 32'd0);

        // Flush mid-ITER at count 10
        start_op(DIV, 32'd12345, 32'd17, 5'd15);
        for (int i = 0; i < 11; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        saw_valid = out_valid;
        for (int i = 0; i < 40; i++) begin
            tick();
            saw_valid = saw_valid | out_valid;
        end
        check("flush_no_valid", {31'd0, saw_valid}, 32'd0);
        $display("txn flush_abort busy=%0b out_valid_seen=%0b", busy, saw_valid);

        // Reset mid-ITER at count 10
        start_op(DIV, 32'd12345, 32'd17, 5'd16);
        for (int i = 0; i < 11; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_tag", {27'd0, out_tag}, 32'd0);
        saw_valid = out_valid;
        for (int i = 0; i < 40; i++) begin
            tick();
            saw_valid = saw_valid | out_valid;
        end
        check("reset_no_valid", {31'd0, saw_valid}, 32'd0);
        $display("txn reset_abort busy=%0b out_valid_seen=%0b", busy, saw_valid);

        run_op("divu_9_3", DIVU, 32'd9, 32'd3, 5'd17, 32'd3, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
